// File: rtl/sqr_seq.sv
// ----------------------------------------------------------------------------
// sqr_seq : sequential integer squarer, dt_o = dt_i * dt_i
//
// Shift-add multiplier with one adder. A result takes WIDTH cycles and the
// latency is fixed. It uses the same enb/busy handshake as the sqrt block.
//
// Ports
//   clk_i    in   1          clock, rising edge
//   rst_ni   in   1          asynchronous active-low reset
//   enb_i    in   1          start request, honoured only while idle
//   dt_i     in   WIDTH      operand, sampled on the start edge only
//   busy_o   out  1          high while a square is being computed
//   done_o   out  1          one-cycle pulse on the edge that writes dt_o
//   dt_o     out  2*WIDTH    last completed square, held until the next one
//
// States
//   S_IDLE | waiting for enb_i; dt_o holds the last result
//   S_CALC | one shift-add step per edge; finishes when r_cnt == WIDTH-1
// ----------------------------------------------------------------------------
module sqr_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enb_i,
    input  logic [WIDTH-1:0]   dt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] dt_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CALC
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_m;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_sum;

    // The multiplicand is zero-extended before shifting so no high bits are
    // lost. The accumulator cannot overflow because (2^W-1)^2 < 2^(2W).
    assign w_addend = r_m[0] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
    assign w_sum    = r_acc + w_addend;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            dt_o    <= '0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enb_i && !busy_o) begin
                        r_a     <= dt_i;
                        r_m     <= dt_i;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy_o  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_sum;
                    r_m   <= r_m >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // The final sum goes straight from the adder to dt_o.
                    // Operand 0 takes the full WIDTH steps; there is no early exit.
                    if (r_cnt == LAST_CNT) begin
                        dt_o    <= w_sum;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqr_seq.sv
// ----------------------------------------------------------------------------
// tb_sqr_seq : directed bench for sqr_seq (WIDTH=8)
//
// A reference model predicts busy/done/dt_o. It uses a remaining-cycles
// counter and a plain multiply. The outputs are compared with the model on
// every falling edge outside reset. Directed sequences add literal checks on
// the results and on the handshake timing.
// ----------------------------------------------------------------------------
module tb_sqr_seq;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           enb;
    logic [W-1:0]   dt_in;
    logic           busy;
    logic           done;
    logic [2*W-1:0] dt_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic mon_en = 1'b0;

    sqr_seq #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .enb_i  (enb),
        .dt_i   (dt_in),
        .busy_o (busy),
        .done_o (done),
        .dt_o   (dt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic           m_busy;
    logic           m_done;
    int             m_left;
    logic [W-1:0]   m_op;
    logic [2*W-1:0] m_dt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_op   <= '0;
            m_dt   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_dt   <= 16'(m_op) * 16'(m_op);
                end
            end else if (enb) begin
                m_busy <= 1'b1;
                m_left <= W;
                m_op   <= dt_in;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("mon_busy", int'(busy), int'(m_busy));
            check("mon_done", int'(done), int'(m_done));
            check("mon_dt",   int'(dt_out), int'(m_dt));
        end
    end

    // ---------------- helpers ----------------
    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Waits for a done pulse, sampled on falling edges. An expired bound
    // counts as a failure.
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] x, output logic [2*W-1:0] res);
        bit ok;
        @(negedge clk);
        enb   = 1'b1;
        dt_in = x;
        @(negedge clk);
        enb = 1'b0;
        wait_done(ok);
        res = dt_out;
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        logic [2*W-1:0] res;
        logic [2*W-1:0] r1, r2, r3;
        int             d1, d2;
        int             bcnt;
        bit             ok;

        rst_n = 1'b0;
        enb   = 1'b0;
        dt_in = '0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dt",   int'(dt_out), 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 1: operand 0 still takes the full 8 cycles
        @(negedge clk);
        enb   = 1'b1;
        dt_in = 8'd0;
        @(negedge clk);
        enb  = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            bcnt++;
            @(negedge clk);
        end
        check("t1_busy_cycles", bcnt, 8);
        check("t1_done", int'(done), 1);
        check("t1_dt", int'(dt_out), 16'h0000);

        // 2: full sweep
        for (int i = 0; i < 256; i++) begin
            run_op(W'(i), res);
            check("t2_sweep", int'(res), i * i);
            if (i == 255) check("t2_255", int'(res), 16'hFE01);
            if (i == 16)  check("t2_16",  int'(res), 16'h0100);
        end

        // 3: enb and dt changes during CALC are ignored
        @(negedge clk);
        enb   = 1'b1;
        dt_in = 8'd200;
        @(negedge clk);
        enb   = 1'b0;
        dt_in = 8'd3;
        wait_done(ok);
        check("t3_dt", int'(dt_out), 40000);
        repeat (3) begin
            @(negedge clk);
            check("t3_no_start", int'(busy), 0);
        end

        // 4: enb held high gives back-to-back ops with a 9-cycle period
        @(negedge clk);
        enb   = 1'b1;
        dt_in = 8'd1;
        @(negedge clk);
        dt_in = 8'd2;
        wait_done(ok);
        r1 = dt_out;
        d1 = cyc;
        check("t4_gap_low", int'(busy), 0);
        @(negedge clk);
        check("t4_gap_high", int'(busy), 1);
        dt_in = 8'd3;
        wait_done(ok);
        r2 = dt_out;
        d2 = cyc;
        check("t4_period", d2 - d1, 9);
        @(negedge clk);
        check("t4_restart", int'(busy), 1);
        enb = 1'b0;
        wait_done(ok);
        r3 = dt_out;
        check("t4_r1", int'(r1), 1);
        check("t4_r2", int'(r2), 4);
        check("t4_r3", int'(r3), 9);

        // 5: reset in the middle of CALC aborts the operation
        @(negedge clk);
        enb   = 1'b1;
        dt_in = 8'd255;
        @(negedge clk);
        enb = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_dt",   int'(dt_out), 0);
        check("t5_rst_done", int'(done), 0);
        @(posedge clk);
        #1;
        check("t5_hold_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        enb   = 1'b1;
        dt_in = 8'd12;
        @(negedge clk);
        check("t5_start_first_edge", int'(busy), 1);
        enb = 1'b0;
        wait_done(ok);
        check("t5_dt", int'(dt_out), 144);

        // 6: round trip, sqrt(x*x) == x
        for (int x = 0; x < 16; x++) begin
            run_op(W'(x), res);
            check("t6_roundtrip", isqrt(int'(res[7:0])), x);
        end

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
